sccb_init_seq: RTL and testbench
================================

# sccb_init_seq

Camera register-initialisation sequencer for the camera debug platform. After reset it waits out the sensor power-up delay, then walks a register table held in an external synchronous ROM and issues one SCCB register write per entry to the SCCB master through a req/ack handshake. NACKed writes are retried, and the sequencer reports busy, done or error status. It runs in the sccb_clk domain, with sccb_reset_n from the clock/reset block.

## Interface
- N_REGS, 32: table depth in entries; legal range 1..2^ADDR_W.
- ADDR_W, 5: ROM address width.
- DLY_CYC, 1024: power-up wait in clk cycles, at least 1.
- GAP_CYC, 16: idle cycles between SCCB transactions, at least 1.
- MAX_RETRY, 3: extra attempts per entry after a NACK.
- AUTO_START, 1: 1 starts the sequence automatically after reset deassertion.
- clk  in  1  sccb_clk domain clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that (re)runs the sequence; honoured only in IDLE, DONE or ERR.
- rom_addr  out  ADDR_W  table address.
- rom_data  in  16  {reg[15:8], val[7:0]}; returned 1 cycle after rom_addr.
- sccb_req  out  1  write request to the SCCB master.
- sccb_reg  out  8  register address.
- sccb_dat  out  8  register value.
- sccb_ack  in  1  one-cycle pulse: transaction finished.
- sccb_nack  in  1  valid only together with sccb_ack; 1 means the slave NACKed.
- busy  out  1  high in every state except IDLE, DONE and ERR.
- done  out  1  high in DONE.
- error  out  1  high in ERR.
- err_idx  out  ADDR_W  index of the failing entry; valid while error is high.

## Operation
- States: IDLE, WAIT, FETCH, LATCH, ISSUE, GAP, DONE, ERR.
- Reset values: state IDLE; rom_addr 0; sccb_req 0; sccb_reg 0; sccb_dat 0; busy, done, error 0; err_idx 0; idx 0; retry 0; delay counter 0.
- IDLE:
  - First cycle after reset release with AUTO_START=1, or a start pulse, goes to WAIT.
  - On entry to WAIT: delay counter := 0, idx := 0, retry := 0, done and error cleared.
- WAIT: counter increments each cycle; at DLY_CYC-1 go to FETCH.
- FETCH: rom_addr := idx; next state LATCH.
- LATCH: rom_data captured into sccb_reg/sccb_dat.
  - Entry 0xFFFF is an end marker: go to DONE.
  - Otherwise go to ISSUE.
- ISSUE:
  - sccb_req=1; sccb_reg and sccb_dat held stable until ack.
  - On sccb_ack: sccb_req drops the next cycle and the state goes to GAP.
    - nack=0: idx++, retry := 0.
    - nack=1 and retry<MAX_RETRY: retry++, idx unchanged.
    - nack=1 and retry=MAX_RETRY: err_idx := idx, go to ERR instead of GAP.
- GAP:
  - Counts GAP_CYC cycles.
  - Then goes to DONE if idx==N_REGS, else to FETCH.
  - idx is ADDR_W+1 bits wide, so idx==N_REGS never wraps.
- DONE and ERR: outputs hold; a start pulse re-enters WAIT, restarting from entry 0 with a full delay.
- Ignored inputs:
  - sccb_ack outside ISSUE.
  - sccb_nack without sccb_ack.
  - start while busy.
- Reset mid-operation: everything returns to the reset values asynchronously, so sccb_req falls immediately. With AUTO_START=1 the sequence restarts from entry 0 after reset release.

## Timing
- All outputs are registered.
- Reset release to first sccb_req with AUTO_START=1: 1 (IDLE) + DLY_CYC + 1 (FETCH) + 1 (LATCH) cycles. sccb_req is high in cycle DLY_CYC+3, counting the first cycle after release as 0.
- Ack to next req: 1 + GAP_CYC + 2 cycles.
- ROM: rom_addr is stable for the FETCH and LATCH cycles; rom_data is sampled in LATCH.
- done or error rises the cycle after the deciding event, and busy falls in the same cycle.
- Ack arriving in the same cycle req first rises: accepted.

## Test plan
- Reset, AUTO_START=1, DLY_CYC=8, 3-entry table {0x1280, 0x1101, 0x6B0A}, N_REGS=3, ack 5 cycles after each req -> three reqs with reg/dat 12/80, 11/01, 6B/0A in that order; first req in cycle 11; done=1 and busy=0 after the last gap.
- Entry 1 = 0xFFFF -> only 12/80 issued; done=1; no second req.
- nack=1 on entry 1 twice, then clean ack -> 11/01 issued 3 times; idx then advances; done=1 and error=0.
- nack=1 on entry 2 four times with MAX_RETRY=3 -> 4 attempts; error=1, err_idx=2, done=0, sccb_req=0.
- reset_n pulsed low while in ISSUE -> sccb_req falls combinationally with reset; after release the sequence restarts with entry 0 after the full delay.
- start pulse during ISSUE is ignored; start in DONE -> new run from entry 0 with a fresh DLY_CYC wait; spurious ack in GAP has no effect.

Source files
------------

// File: rtl/sccb_init_seq.sv
// sccb_init_seq
//   Camera register-initialisation sequencer. After reset (or a start pulse)
//   it waits out the sensor power-up delay. It then reads a register table
//   from an external synchronous ROM and issues one SCCB write per entry
//   through a req/ack handshake. A NACKed write is retried up to MAX_RETRY
//   extra times before the sequencer gives up and reports an error.
//
// Ports
//   clk_i        sccb_clk domain clock
//   reset_n_i    asynchronous active-low reset
//   start_i      one-cycle pulse, (re)runs the sequence from IDLE/DONE/ERR
//   rom_addr_o   table address (ROM answers one cycle later)
//   rom_data_i   {reg[15:8], val[7:0]}; 16'hFFFF marks end of table
//   sccb_req_o   write request to the SCCB master
//   sccb_reg_o   register address of the current write
//   sccb_dat_o   register value of the current write
//   sccb_ack_i   one-cycle pulse: transaction finished
//   sccb_nack_i  qualifies sccb_ack_i; 1 = slave NACKed
//   busy_o       high while a sequence is running
//   done_o       high once the table has been written completely
//   error_o      high after an entry ran out of retries
//   err_idx_o    index of the entry that failed
module sccb_init_seq #(
  parameter int N_REGS     = 32,
  parameter int ADDR_W     = 5,
  parameter int DLY_CYC    = 1024,
  parameter int GAP_CYC    = 16,
  parameter int MAX_RETRY  = 3,
  parameter int AUTO_START = 1
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              start_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [15:0]       rom_data_i,
  output logic              sccb_req_o,
  output logic [7:0]        sccb_reg_o,
  output logic [7:0]        sccb_dat_o,
  input  logic              sccb_ack_i,
  input  logic              sccb_nack_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [ADDR_W-1:0] err_idx_o
);

  // idx has one extra bit so that idx == N_REGS is representable even when
  // the table fills the whole ROM address space.
  localparam int IDX_W   = ADDR_W + 1;
  localparam int CNT_MAX = (DLY_CYC > GAP_CYC) ? DLY_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_LATCH = 3'd3;
  localparam logic [2:0] S_ISSUE = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_ERR   = 3'd7;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [RTY_W-1:0]  retry_q, retry_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              req_q, req_d;
  logic [7:0]        reg_q, reg_d;
  logic [7:0]        dat_q, dat_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [ADDR_W-1:0] err_idx_q, err_idx_d;
  // Set only during the first cycle after reset release, for auto-start.
  logic              first_q;
  logic              go_wait;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    retry_d    = retry_q;
    rom_addr_d = rom_addr_q;
    reg_d      = reg_q;
    dat_d      = dat_q;
    err_idx_d  = err_idx_q;
    go_wait    = 1'b0;

    case (state_q)
      S_IDLE: go_wait = (first_q && (AUTO_START != 0)) || start_i;
      S_WAIT: begin
        if (cnt_q == CNT_W'(DLY_CYC - 1)) begin
          state_d    = S_FETCH;
          rom_addr_d = idx_q[ADDR_W-1:0];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        reg_d   = rom_data_i[15:8];
        dat_d   = rom_data_i[7:0];
        state_d = (rom_data_i == 16'hFFFF) ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        if (sccb_ack_i) begin
          cnt_d = '0;
          if (!sccb_nack_i) begin
            idx_d   = idx_q + IDX_W'(1);
            retry_d = '0;
            state_d = S_GAP;
          end else if (retry_q < RTY_W'(MAX_RETRY)) begin
            retry_d = retry_q + RTY_W'(1);
            state_d = S_GAP;
          end else begin
            err_idx_d = idx_q[ADDR_W-1:0];
            state_d   = S_ERR;
          end
        end
      end
      S_GAP: begin
        if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
          if (idx_q == IDX_W'(N_REGS)) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_FETCH;
            rom_addr_d = idx_q[ADDR_W-1:0];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE, S_ERR: go_wait = start_i;
      default: state_d = S_IDLE;
    endcase

    if (go_wait) begin
      state_d = S_WAIT;
      cnt_d   = '0;
      idx_d   = '0;
      retry_d = '0;
    end

    // Status and request are derived from the next state so that every
    // output is a plain register that changes together with the state.
    req_d   = (state_d == S_ISSUE);
    busy_d  = !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERR));
    done_d  = (state_d == S_DONE);
    error_d = (state_d == S_ERR);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      retry_q    <= '0;
      rom_addr_q <= '0;
      req_q      <= 1'b0;
      reg_q      <= '0;
      dat_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_idx_q  <= '0;
      first_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      retry_q    <= retry_d;
      rom_addr_q <= rom_addr_d;
      req_q      <= req_d;
      reg_q      <= reg_d;
      dat_q      <= dat_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_idx_q  <= err_idx_d;
      first_q    <= 1'b0;
    end
  end

  assign rom_addr_o = rom_addr_q;
  assign sccb_req_o = req_q;
  assign sccb_reg_o = reg_q;
  assign sccb_dat_o = dat_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign error_o    = error_q;
  assign err_idx_o  = err_idx_q;

endmodule

// File: tb/tb_sccb_init_seq.sv
// tb_sccb_init_seq
//   Scoreboard bench for sccb_init_seq. The stimulus process loads the ROM
//   model, queues the expected SCCB writes (register/value and, where known,
//   the cycle of the request) and the NACK pattern the slave model answers
//   with. A monitor pops one expectation per rising sccb_req; a responder
//   acks each request a fixed number of cycles after it rises.
module tb_sccb_init_seq;

  localparam int ADDR_W  = 5;
  localparam int ACK_DLY = 5;

  typedef struct {
    logic [7:0] r;
    logic [7:0] d;
    int         cyc;
  } exp_t;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_data;
  logic              sccb_req;
  logic [7:0]        sccb_reg;
  logic [7:0]        sccb_dat;
  logic              sccb_ack;
  logic              sccb_nack;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W-1:0] err_idx;

  logic [15:0] rom_mem [0:31];
  exp_t        exp_q[$];
  bit          nack_q[$];
  bit          spur_en;
  int          checks;
  int          errors;
  int          cyc;
  int          n_req;

  sccb_init_seq #(
    .N_REGS(3), .ADDR_W(ADDR_W), .DLY_CYC(8), .GAP_CYC(4),
    .MAX_RETRY(3), .AUTO_START(1)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start),
    .rom_addr_o(rom_addr), .rom_data_i(rom_data),
    .sccb_req_o(sccb_req), .sccb_reg_o(sccb_reg), .sccb_dat_o(sccb_dat),
    .sccb_ack_i(sccb_ack), .sccb_nack_i(sccb_nack),
    .busy_o(busy), .done_o(done), .error_o(error), .err_idx_o(err_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle 0 is the first cycle after reset release.
  always @(posedge clk or negedge reset_n)
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;

  // Synchronous ROM model: one cycle read latency.
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  function automatic void check(string name, int act, int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Slave model: ack ACK_DLY cycles after req rises; optional spurious
  // ack/nack inside the gap that follows each real ack.
  initial begin
    int req_age;
    int since_ack;
    sccb_ack = 1'b0; sccb_nack = 1'b0;
    req_age = 0; since_ack = 100;
    forever begin
      @(negedge clk);
      sccb_ack = 1'b0; sccb_nack = 1'b0;
      if (since_ack < 100) since_ack++;
      if (sccb_req) begin
        if (req_age == ACK_DLY) begin
          sccb_ack  = 1'b1;
          sccb_nack = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
          since_ack = 0;
        end
        req_age++;
      end else begin
        req_age = 0;
        if (spur_en && since_ack == 2) begin sccb_ack = 1'b1; sccb_nack = 1'b1; end
        if (spur_en && since_ack == 3) sccb_nack = 1'b1;
      end
    end
  end

  // Monitor: one scoreboard pop per request, stability check while held.
  initial begin
    logic req_prev;
    exp_t cur;
    req_prev = 1'b0;
    cur.r = 8'h00; cur.d = 8'h00; cur.cyc = -1;
    forever begin
      @(negedge clk);
      if (sccb_req && !req_prev) begin
        n_req++;
        $display("req %0d: cycle %0d reg 0x%02h dat 0x%02h", n_req, cyc, sccb_reg, sccb_dat);
        if (exp_q.size() == 0) begin
          check("unexpected_req", {16'h0, sccb_reg, sccb_dat}, -1);
        end else begin
          cur = exp_q.pop_front();
          check("req_reg_dat", {16'h0, sccb_reg, sccb_dat}, {16'h0, cur.r, cur.d});
          if (cur.cyc >= 0) check("req_cycle", cyc, cur.cyc);
        end
      end else if (sccb_req) begin
        check("req_hold", {16'h0, sccb_reg, sccb_dat}, {16'h0, cur.r, cur.d});
      end
      req_prev = sccb_req;
    end
  end

  task automatic push_exp(input logic [15:0] e, input int c);
    exp_t x;
    x.r = e[15:8]; x.d = e[7:0]; x.cyc = c;
    exp_q.push_back(x);
  endtask

  task automatic pulse_start(output int s);
    @(negedge clk);
    s = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_req(input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (sccb_req) return;
    end
    check("wait_req_timeout", 0, 1);
  endtask

  task automatic wait_end(input int max, output int at);
    at = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (done || error) begin at = cyc; return; end
    end
    check("wait_end_timeout", 0, 1);
  endtask

  task automatic load_table();
    for (int i = 0; i < 32; i++) rom_mem[i] = 16'h0000;
    rom_mem[0] = 16'h1280;
    rom_mem[1] = 16'h1101;
    rom_mem[2] = 16'h6B0A;
  endtask

  initial begin
    int s;
    int at;
    checks = 0; errors = 0; n_req = 0;
    start = 1'b0; spur_en = 1'b0;
    load_table();

    // Reset values
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req", sccb_req, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_reg_dat", {sccb_reg, sccb_dat}, 0);
    check("rst_err_idx", err_idx, 0);

    // Auto-start run; start during ISSUE ignored; spurious ack/nack in GAP.
    push_exp(16'h1280, 11);
    push_exp(16'h1101, 23);
    push_exp(16'h6B0A, 35);
    spur_en = 1'b1;
    reset_n = 1'b1;
    wait_req(40);
    check("busy_in_issue", busy, 1);
    @(negedge clk);
    pulse_start(s);
    wait_end(200, at);
    spur_en = 1'b0;
    check("t1_done_cycle", at, 45);
    check("t1_done", done, 1);
    check("t1_busy", busy, 0);
    check("t1_error", error, 0);
    check("t1_queue_empty", exp_q.size(), 0);

    // Start from DONE with an end marker at entry 1.
    rom_mem[1] = 16'hFFFF;
    pulse_start(s);
    push_exp(16'h1280, s + 11);
    wait_end(200, at);
    check("t2_done_cycle", at, s + 23);
    check("t2_done", done, 1);
    check("t2_busy", busy, 0);
    check("t2_queue_empty", exp_q.size(), 0);

    // Two NACKs on entry 1, then a clean ack.
    load_table();
    nack_q = '{0, 1, 1, 0, 0};
    pulse_start(s);
    push_exp(16'h1280, s + 11);
    push_exp(16'h1101, s + 23);
    push_exp(16'h1101, s + 35);
    push_exp(16'h1101, s + 47);
    push_exp(16'h6B0A, s + 59);
    wait_end(300, at);
    check("t3_done_cycle", at, s + 69);
    check("t3_done", done, 1);
    check("t3_error", error, 0);
    check("t3_queue_empty", exp_q.size(), 0);

    // Entry 2 NACKed on every attempt: four tries then ERR.
    nack_q = '{0, 0, 1, 1, 1, 1};
    pulse_start(s);
    push_exp(16'h1280, s + 11);
    push_exp(16'h1101, s + 23);
    for (int i = 0; i < 4; i++) push_exp(16'h6B0A, s + 35 + 12 * i);
    wait_end(300, at);
    check("t4_err_cycle", at, s + 77);
    check("t4_error", error, 1);
    check("t4_err_idx", err_idx, 2);
    check("t4_done", done, 0);
    check("t4_busy", busy, 0);
    check("t4_req", sccb_req, 0);
    check("t4_queue_empty", exp_q.size(), 0);

    // Start from ERR, reset in ISSUE, auto-restart from entry 0.
    pulse_start(s);
    push_exp(16'h1280, s + 11);
    wait_req(40);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("t5_req_async", sccb_req, 0);
    check("t5_error_async", error, 0);
    check("t5_busy_async", busy, 0);
    nack_q.delete();
    check("t5_queue_empty", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    push_exp(16'h1280, 11);
    push_exp(16'h1101, 23);
    push_exp(16'h6B0A, 35);
    reset_n = 1'b1;
    wait_end(200, at);
    check("t5_done_cycle", at, 45);
    check("t5_done", done, 1);
    check("t5_queue_empty_end", exp_q.size(), 0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1, "timeout");
  end

endmodule
